// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per frame.
// Define ICACHE_STATS_EN to add the saturating hit_count/miss_count ports.
module icache_direct_mapped #(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic [0:0] {StIdle, StFetch} state_e;

    state_e           r_state;
    logic             r_iren;
    logic [31:0]      r_iaddr;
    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [SETS];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0] w_fill_tag;
    logic             w_hit;
    logic             w_miss;
    logic             w_fill;
    logic             w_unused_lsbs;

    assign w_idx         = imemaddr[IDX_W+1:2];
    assign w_tag         = imemaddr[31:IDX_W+2];
    assign w_fill_idx    = r_iaddr[IDX_W+1:2];
    assign w_fill_tag    = r_iaddr[31:IDX_W+2];
    assign w_unused_lsbs = ^imemaddr[1:0];

    // Lookups only happen in IDLE, so a fill and a lookup never overlap.
    assign w_hit  = (r_state == StIdle) && imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss = (r_state == StIdle) && imemREN && !w_hit;
    assign w_fill = (r_state == StFetch) && !iwait;

    assign ihit     = w_hit;
    assign imemload = w_hit ? r_data[w_idx] : 32'h0;
    assign iREN     = r_iren;
    assign iaddr    = r_iaddr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StIdle;
            r_iren  <= 1'b0;
            r_iaddr <= 32'h0;
            r_valid <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_miss) begin
                        r_state <= StFetch;
                        r_iren  <= 1'b1;
                        r_iaddr <= {imemaddr[31:2], 2'b00};
                    end
                end
                StFetch: begin
                    if (!iwait) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        r_state             <= StIdle;
                        r_iren              <= 1'b0;
                        r_iaddr             <= 32'h0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Tag/data need no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hit_count  <= 32'h0;
            r_miss_count <= 32'h0;
        end else begin
            if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Randomised self-checking bench for icache_direct_mapped against an address-level cache model,
// plus directed literal checks; ICACHE_STATS_EN also checks the counters.
module tb_icache_direct_mapped;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    icache_direct_mapped #(.SETS(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Backing memory: a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2001_0005;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign iload = mem_word(iaddr);

    function automatic int f_idx(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    function automatic logic [31:0] f_word(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    // Model: each index remembers the word address it currently holds.
    logic [31:0] m_lines [int];
    logic        m_busy;
    logic [31:0] m_pend;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    function automatic logic model_hit(input logic [31:0] a);
        return m_lines.exists(f_idx(a)) && (m_lines[f_idx(a)] == f_word(a));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_lines.delete();
            m_busy   = 1'b0;
            m_pend   = 32'h0;
            m_hits   = 32'h0;
            m_misses = 32'h0;
        end else if (m_busy) begin
            if (!iwait) begin
                m_lines[f_idx(m_pend)] = m_pend;
                m_busy = 1'b0;
            end
        end else if (imemREN) begin
            if (model_hit(imemaddr)) begin
                if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
            end else begin
                m_busy = 1'b1;
                m_pend = f_word(imemaddr);
                if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            logic h;
            h = !m_busy && imemREN && model_hit(imemaddr);
            chk("cmp_ihit", 32'(ihit), 32'(h));
            chk("cmp_imemload", imemload, h ? mem_word(f_word(imemaddr)) : 32'h0);
            chk("cmp_iREN", 32'(iREN), 32'(m_busy));
            chk("cmp_iaddr", iaddr, m_busy ? m_pend : 32'h0);
`ifdef ICACHE_STATS_EN
            chk("cmp_hit_count", hit_count, m_hits);
            chk("cmp_miss_count", miss_count, m_misses);
`endif
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Miss on addr, memory busy for nwait cycles, then the hit cycle.
    task automatic expect_miss(input logic [31:0] addr, input int nwait, input string name);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        @(negedge CLK);
        chk({name, "_miss"}, 32'(ihit), 32'h0);
        next_cycle();
        for (int i = 0; i <= nwait; i++) begin
            iwait = (i < nwait);
            @(negedge CLK);
            chk({name, "_iREN"}, 32'(iREN), 32'h1);
            chk({name, "_iaddr"}, iaddr, addr & 32'hFFFF_FFFC);
            next_cycle();
        end
        iwait = 1'b1;
        @(negedge CLK);
        chk({name, "_hit"}, 32'(ihit), 32'h1);
        chk({name, "_data"}, imemload, mem_word(addr & 32'hFFFF_FFFC));
        next_cycle();
    endtask

    logic [25:0] tags [4];

    initial begin
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iwait    = 1'b0;
        @(negedge CLK);
        chk("rst_iREN", 32'(iREN), 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_ihit", 32'(ihit), 32'h0);
        chk("rst_imemload", imemload, 32'h0);
        next_cycle();
        RST = 1'b0;

        // Cold miss: 3 busy cycles -> iREN for 4 cycles, then hit.
        expect_miss(32'h0000_0040, 3, "cold");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("repeat_hit", 32'(ihit), 32'h1);
            chk("repeat_data", imemload, 32'h2001_0005);
            chk("repeat_iREN", 32'(iREN), 32'h0);
            next_cycle();
        end
        imemREN = 1'b0;
        @(negedge CLK);
        chk("noreq_ihit", 32'(ihit), 32'h0);
        chk("noreq_imemload", imemload, 32'h0);
`ifdef ICACHE_STATS_EN
        chk("stats_hits4", hit_count, 32'd4);
        chk("stats_miss1", miss_count, 32'd1);
`endif
        next_cycle();

        // Conflict at idx 0.
        expect_miss(32'h0000_0080, 1, "conflict_80");
        expect_miss(32'h0000_0041, 0, "conflict_40");

        // Address change mid-fill.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0100;
        iwait    = 1'b1;
        @(negedge CLK);
        chk("midfill_miss", 32'(ihit), 32'h0);
        next_cycle();
        imemaddr = 32'h0000_0104;
        for (int i = 0; i < 3; i++) begin
            iwait = (i < 2);
            @(negedge CLK);
            chk("midfill_iaddr", iaddr, 32'h0000_0100);
            next_cycle();
        end
        iwait = 1'b0;
        @(negedge CLK);
        chk("midfill_104_miss", 32'(ihit), 32'h0);
        next_cycle();
        @(negedge CLK);
        chk("midfill_104_iaddr", iaddr, 32'h0000_0104);
        next_cycle();
        iwait = 1'b1;
        @(negedge CLK);
        chk("midfill_104_hit", 32'(ihit), 32'h1);
        next_cycle();
        imemaddr = 32'h0000_0100;
        @(negedge CLK);
        chk("midfill_100_hit", 32'(ihit), 32'h1);
        chk("midfill_100_data", imemload, mem_word(32'h0000_0100));
        next_cycle();

        // Asynchronous reset during FETCH.
        imemaddr = 32'h0000_0200;
        @(negedge CLK);
        chk("rstmid_miss", 32'(ihit), 32'h0);
        next_cycle();
        #1 RST = 1'b1;
        #1;
        chk("rstmid_iREN", 32'(iREN), 32'h0);
        chk("rstmid_iaddr", iaddr, 32'h0);
        next_cycle();
        RST = 1'b0;
        expect_miss(32'h0000_0200, 0, "rstmid_refetch");
        expect_miss(32'h0000_0100, 0, "rstmid_100");

        // Randomised traffic over a few aliasing tags.
        tags[0] = 26'd1;
        for (int k = 1; k < 4; k++) tags[k] = 26'($urandom());
        for (int c = 0; c < 2000; c++) begin
            imemREN  = ($urandom_range(0, 3) != 0);
            imemaddr = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
                        2'($urandom_range(0, 3))};
            iwait    = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 299) == 0) begin
                #1 RST = 1'b1;
                #1 RST = 1'b0;
            end
            next_cycle();
        end

`ifdef ICACHE_STATS_EN
        #1 RST = 1'b1;
        #1 RST = 1'b0;
        next_cycle();
        expect_miss(32'h0000_0040, 0, "sat_fill");
        imemaddr = 32'h0000_0040;
        iwait    = 1'b1;
        force dut.r_hit_count = 32'hFFFF_FFFF;
        #1 release dut.r_hit_count;
        m_hits = 32'hFFFF_FFFF;
        @(negedge CLK);
        chk("sat_hit_now", 32'(ihit), 32'h1);
        next_cycle();
        @(negedge CLK);
        chk("sat_hit_count", hit_count, 32'hFFFF_FFFF);
        next_cycle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
